pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/ready + rvalid interface, with at most one request outstanding.
- Buffers returned words in a small FIFO and presents one {addr, inst} pair per cycle to IF/ID.
- Handles hold from ctrl and jump redirects from EX, including killing a stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FQ_DEPTH, 4, fetch FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- hold_flag_i  in  1  from ctrl: stall; do not pop the FIFO.
- jump_en_i  in  1  from ex: single-cycle redirect strobe.
- jump_addr_i  in  32  from ex: redirect target.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address (current PC).
- imem_ready_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  read data.
- inst_addr_o  out  32  to if_id: instruction address.
- inst_o  out  32  to if_id: instruction, or INST_NOP when no valid instruction.
- inst_valid_o  out  1  head popped this cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, FIFO empty, FSM=IDLE, kill=0.
  - Combinational outputs while in reset: imem_req_o=0, inst_o=INST_NOP, inst_addr_o=0, inst_valid_o=0.
  - Reset mid-wait: the pending response is dropped, because FSM=IDLE ignores rvalid.
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding.
  - WAIT_KILL: one request outstanding whose data will be discarded.
- Request rule:
  - imem_req_o = (FSM==IDLE, or FSM==WAIT with imem_rvalid_i) AND (fifo_count + (FSM!=IDLE) < FQ_DEPTH) AND NOT jump_en_i.
  - imem_addr_o = pc.
- Accept (imem_req_o & imem_ready_i):
  - req_pc <= pc; pc <= pc + 4 (32-bit wrap: 32'hFFFF_FFFC -> 0); FSM -> WAIT.
- Response:
  - In WAIT with imem_rvalid_i: push {req_pc, imem_rdata_i}.
  - FSM -> IDLE, or stays WAIT if a new accept occurs the same cycle (back-to-back issue).
  - In WAIT_KILL with imem_rvalid_i: data discarded, FSM -> IDLE.
  - rvalid in IDLE: ignored; the bench flags it as a protocol error.
- Jump (highest priority, overrides hold):
  - pc <= jump_addr_i; FIFO flushed; no push and no pop this cycle.
  - FSM: WAIT -> WAIT_KILL; IDLE stays IDLE.
  - A response arriving in the same cycle as the jump is discarded.
  - Outputs this cycle: inst_o=INST_NOP, inst_valid_o=0.
  - The first request to the target issues the next cycle.
- Output and pop:
  - pop = !hold_flag_i & !jump_en_i & !empty.
  - When pop=1: inst_o/inst_addr_o = FIFO head, inst_valid_o=1.
  - Otherwise: inst_o=INST_NOP, inst_addr_o=0, inst_valid_o=0.
  - Outputs are combinational from the FIFO head. IF/ID registers them, so end-to-end latency is fetch-accept + memory latency + 1 cycle.
- FIFO boundaries:
  - Push and pop in the same cycle on a full FIFO is legal; count is unchanged.
  - Push to a full FIFO cannot occur because of the request rule's room check.
  - A hold of any length loses no instruction.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misalign_o (1 bit).
  - When jump_en_i & jump_addr_i[1:0]!=0: misalign_o pulses high for 1 cycle; pc <= jump_addr_i; fetch is halted (no requests) until the next jump_en_i.
  - misalign_o resets to 0.
- Not defined:
  - No misalign_o port; the target is used as {jump_addr_i[31:2], 2'b00}.

Decomposition:
- Shared defines/package:
  - INST_NOP (existing).
  - FSM state encodings (IDLE/WAIT/WAIT_KILL, 2 bits).
  - PC increment constant 4.
- One sub-module: fetch_fifo.
  - Parameterized width (64) and depth.
  - Synchronous flush.
  - Outputs: count, full, empty, head.
  - Read-first; push and pop allowed in the same cycle.

Test Plan:
- Reset, imem_ready_i=1, rvalid returned 1 cycle after each accept with rdata=addr^32'hA5A5_0000 -> fetches at 0,4,8,…; IF/ID sees addr 0 with inst 32'hA5A5_0000, then ascending addresses with no gaps after warm-up.
- hold_flag_i=1 for 10 cycles with a memory that always responds -> FIFO fills to 4 and imem_req_o drops; on release, addrs continue in order with none lost or duplicated.
- Request at addr 8 accepted, jump_en_i to 32'h100 before its rvalid -> FSM=WAIT_KILL, data at addr 8 never reaches inst_o; next issued address is 32'h100.
- jump_en_i asserted in the same cycle as rvalid -> response discarded, FIFO empty, inst_o=INST_NOP, next request at the jump target.
- Reset at 32'hFFFF_FFF8, responses for 3 fetches -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With FETCH_MISALIGN_CHK_EN defined, jump to 32'h102 -> misalign_o=1 for one cycle and no requests; a later jump to 32'h200 resumes fetching. Without the macro, the same jump fetches from 32'h100.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pc_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_fifo.sv
// Small read-first FIFO holding fetched {addr, inst} pairs; synchronous flush.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, single-outstanding imem fetch, fetch FIFO to IF/ID.
// Optional FETCH_MISALIGN_CHK_EN adds misalign_o and halts fetch on misaligned jump targets.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_flag_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e  state, state_nxt;
  logic [31:0]   pc, pc_nxt, req_pc, jump_target;
  logic          req, accept, push, pop, outstanding, room, fetch_halt;
  logic [CW-1:0] count;
  logic          full, empty;
  fetch_entry_t  head, wentry;

`ifdef FETCH_MISALIGN_CHK_EN
  logic halted;
  logic bad_jump;

  assign bad_jump    = jump_en_i && (jump_addr_i[1:0] != 2'b00);
  assign jump_target = jump_addr_i;
  assign fetch_halt  = halted;

  // Misaligned jump parks the fetcher until the next jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted     <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= bad_jump;
      if (jump_en_i) halted <= bad_jump;
    end
  end
`else
  assign jump_target = jump_addr_i & ~32'h0000_0003;
  assign fetch_halt  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (accept) req_pc <= pc;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    outstanding  = (state != ST_IDLE);
    room         = (32'(count) + 32'(outstanding)) < FQ_DEPTH;
    req          = 1'b0;
    accept       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    wentry       = '{addr: req_pc, inst: imem_rdata_i};
    imem_req_o   = 1'b0;
    imem_addr_o  = pc;
    inst_addr_o  = '0;
    inst_o       = INST_NOP;
    inst_valid_o = 1'b0;

    if (!rst) begin
      req    = !fetch_halt && !jump_en_i && room &&
               ((state == ST_IDLE) || ((state == ST_WAIT) && imem_rvalid_i));
      accept = req && imem_ready_i;
      pop    = !hold_flag_i && !jump_en_i && !empty;
      push   = (state == ST_WAIT) && imem_rvalid_i && !jump_en_i && (!full || pop);
    end

    // Jump wins: redirect, and either retire or mark the in-flight fetch as stale.
    if (jump_en_i) begin
      pc_nxt = jump_target;
      if (outstanding && imem_rvalid_i) state_nxt = ST_IDLE;
      else if (state == ST_WAIT)        state_nxt = ST_WAIT_KILL;
    end else begin
      if (accept) pc_nxt = pc + PC_INC;
      unique case (state)
        ST_IDLE:      if (accept) state_nxt = ST_WAIT;
        ST_WAIT:      if (imem_rvalid_i) state_nxt = accept ? ST_WAIT : ST_IDLE;
        ST_WAIT_KILL: if (imem_rvalid_i) state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end

    imem_req_o = req;
    if (pop) begin
      inst_addr_o  = head.addr;
      inst_o       = head.inst;
      inst_valid_o = 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_en_i),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed, table-driven bench for pc_fetch; memory responses are scripted per cycle.
module tb_pc_fetch;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;
  localparam logic [31:0] XMASK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold_flag = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        inst_valid;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          r, h, j;
    logic [31:0] ja;
    bit          rdy, rv;
    logic [31:0] rd;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_iaddr;
    logic [31:0] e_inst;
  } vec_t;

  pc_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .hold_flag_i   (hold_flag),
    .jump_en_i     (jump_en),
    .jump_addr_i   (jump_addr),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ready_i  (imem_ready),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .inst_addr_o   (inst_addr),
    .inst_o        (inst),
    .inst_valid_o  (inst_valid)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_o    (misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory data for address a is a ^ XMASK; expected inst follows the same rule.
  function automatic vec_t mk(bit r, bit h, bit j, logic [31:0] ja, bit rdy, bit rv,
                              logic [31:0] raddr, bit er, logic [31:0] ea,
                              bit ev, logic [31:0] eia);
    vec_t v;
    v.r = r; v.h = h; v.j = j; v.ja = ja; v.rdy = rdy; v.rv = rv;
    v.rd      = raddr ^ XMASK;
    v.e_req   = er;
    v.e_addr  = ea;
    v.e_valid = ev;
    v.e_iaddr = ev ? eia : 32'h0;
    v.e_inst  = ev ? (eia ^ XMASK) : TB_NOP;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    rst = v.r; hold_flag = v.h; jump_en = v.j; jump_addr = v.ja;
    imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rd;
    @(negedge clk);
    check({name, " req"}, 32'(imem_req), 32'(v.e_req));
    if (v.e_req) check({name, " imem_addr"}, imem_addr, v.e_addr);
    check({name, " valid"}, 32'(inst_valid), 32'(v.e_valid));
    check({name, " inst_addr"}, inst_addr, v.e_iaddr);
    check({name, " inst"}, inst, v.e_inst);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // Reset, warm-up streaming, then a hold that fills the FIFO and its release.
    tbl.push_back(mk(1,0,0,0, 1,0,0,      0,0,      0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,      1,32'h0,  0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,32'h0,  1,32'h4,  0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,32'h4,  1,32'h8,  1,32'h0));
    tbl.push_back(mk(0,0,0,0, 1,1,32'h8,  1,32'hC,  1,32'h4));
    tbl.push_back(mk(0,0,0,0, 1,1,32'hC,  1,32'h10, 1,32'h8));
    tbl.push_back(mk(0,1,0,0, 1,1,32'h10, 1,32'h14, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,1,32'h14, 1,32'h18, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,1,32'h18, 0,0,      0,0));
    tbl.push_back(mk(0,1,0,0, 1,0,0,      0,0,      0,0));
    tbl.push_back(mk(0,1,0,0, 1,0,0,      0,0,      0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,      0,0,      1,32'hC));
    tbl.push_back(mk(0,0,0,0, 1,0,0,      1,32'h1C, 1,32'h10));
    tbl.push_back(mk(0,0,0,0, 1,1,32'h1C, 1,32'h20, 1,32'h14));
    tbl.push_back(mk(0,0,0,0, 1,1,32'h20, 1,32'h24, 1,32'h18));
    tbl.push_back(mk(0,0,0,0, 1,1,32'h24, 1,32'h28, 1,32'h1C));
    tbl.push_back(mk(0,0,0,0, 1,1,32'h28, 1,32'h2C, 1,32'h20));

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("stream[%0d]", i), tbl[i]);

    // Jump while fetch of 0x8 is in flight: its data must never surface.
    apply("kill0", mk(1,0,0,0,      1,0,0,      0,0,       0,0));
    apply("kill1", mk(0,0,0,0,      1,0,0,      1,32'h0,   0,0));
    apply("kill2", mk(0,0,0,0,      1,1,32'h0,  1,32'h4,   0,0));
    apply("kill3", mk(0,0,0,0,      1,1,32'h4,  1,32'h8,   1,32'h0));
    apply("kill4", mk(0,0,1,32'h100,1,0,0,      0,0,       0,0));
    apply("kill5", mk(0,0,0,0,      1,1,32'h8,  0,0,       0,0));
    apply("kill6", mk(0,0,0,0,      1,0,0,      1,32'h100, 0,0));
    apply("kill7", mk(0,0,0,0,      1,1,32'h100,1,32'h104, 0,0));
    apply("kill8", mk(0,0,0,0,      1,1,32'h104,1,32'h108, 1,32'h100));

    // Jump coincident with rvalid: response dropped, target fetched next cycle.
    apply("jrv0", mk(0,0,1,32'h40, 1,1,32'h108, 0,0,      0,0));
    apply("jrv1", mk(0,0,0,0,      1,0,0,       1,32'h40, 0,0));
    apply("jrv2", mk(0,0,0,0,      1,1,32'h40,  1,32'h44, 0,0));
    apply("jrv3", mk(0,0,0,0,      1,1,32'h44,  1,32'h48, 1,32'h40));

    // PC wrap through the top of the address space.
    apply("wrap0", mk(0,0,1,32'hFFFF_FFF8, 1,0,0,            0,0,            0,0));
    apply("wrap1", mk(0,0,0,0,             1,1,32'h48,       0,0,            0,0));
    apply("wrap2", mk(0,0,0,0,             1,0,0,            1,32'hFFFF_FFF8,0,0));
    apply("wrap3", mk(0,0,0,0,             1,1,32'hFFFF_FFF8,1,32'hFFFF_FFFC,0,0));
    apply("wrap4", mk(0,0,0,0,             1,1,32'hFFFF_FFFC,1,32'h0,        1,32'hFFFF_FFF8));
    apply("wrap5", mk(0,0,0,0,             1,1,32'h0,        1,32'h4,        1,32'hFFFF_FFFC));
    apply("wrap6", mk(0,0,0,0,             1,1,32'h4,        1,32'h8,        1,32'h0));

    // Misaligned jump target, then an aligned jump.
    apply("mis0", mk(0,0,1,32'h102, 1,1,32'h8, 0,0, 0,0));
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis pulse", 32'(misalign), 32'h1);
    apply("mis1", mk(0,0,0,0,       0,0,0,     0,0, 0,0));
    check("mis clear", 32'(misalign), 32'h0);
`else
    apply("mis1", mk(0,0,0,0,       0,0,0,     1,32'h100, 0,0));
`endif
    apply("mis2", mk(0,0,1,32'h200, 0,0,0,     0,0,        0,0));
    apply("mis3", mk(0,0,0,0,       1,0,0,     1,32'h200,  0,0));

    // Reset with a fetch outstanding: the late response is ignored.
    apply("rstw0", mk(1,0,0,0, 0,0,0,      0,0,     0,0));
    apply("rstw1", mk(0,0,0,0, 0,1,32'h200,1,32'h0, 0,0));
    apply("rstw2", mk(0,0,0,0, 0,0,0,      1,32'h0, 0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
